// File: rtl/riscv_lsu_amo.sv
// RV12 EX-stage load/store unit: pipelined LOAD/STORE plus optional A-extension (LR/SC, locked AMOs).
// Define RV12_LSU_AMO_EN to build the LR/SC/AMO sequencer and reservation register.

package riscv_lsu_amo_pkg;
  typedef enum logic [2:0] {
    BYTE       = 3'b000,
    HWORD      = 3'b001,
    WORD       = 3'b010,
    DWORD      = 3'b011,
    QWORD      = 3'b100,
    UNDEF_SIZE = 3'b111
  } biu_size_t;
endpackage

module riscv_lsu_amo
  import riscv_lsu_amo_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RSV_GRAN = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ex_stall_i,
  input  logic            op_valid_i,
  input  logic [3:0]      op_i,
  input  biu_size_t       size_i,
  input  logic [XLEN-1:0] adr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            lsu_stall_o,
  output logic            lsu_bubble_o,
  output logic [XLEN-1:0] lsu_r_o,
  output logic            lsu_misaligned_o,
  output logic            lsu_page_fault_o,
  output logic            dmem_req_o,
  output logic            dmem_lock_o,
  output logic            dmem_we_o,
  output biu_size_t       dmem_size_o,
  output logic [XLEN-1:0] dmem_adr_o,
  output logic [XLEN-1:0] dmem_d_o,
  input  logic            dmem_ack_i,
  input  logic [XLEN-1:0] dmem_q_i,
  input  logic            dmem_misaligned_i,
  input  logic            dmem_page_fault_i
);
  localparam int LB = $clog2(XLEN/8);
  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;

  logic            req_r, we_r, bubble_r, misaligned_r, page_fault_r;
  biu_size_t       size_r;
  logic [XLEN-1:0] adr_r, d_r, r_r;
  logic            req_s, we_s, bubble_s, misaligned_s, page_fault_s;
  biu_size_t       size_s;
  logic [XLEN-1:0] adr_s, d_s, r_s;
  logic            idle_s, accept_s, biu_err_s;

  function automatic logic [XLEN-1:0] lane_shift(input logic [XLEN-1:0] v, input logic [XLEN-1:0] a);
    return v << {a[LB-1:0], 3'b000};
  endfunction

  assign accept_s  = idle_s & op_valid_i & ~ex_stall_i;
  assign biu_err_s = dmem_ack_i & (dmem_misaligned_i | dmem_page_fault_i);

`ifdef RV12_LSU_AMO_EN
  localparam logic [3:0] OP_LR   = 4'd2;
  localparam logic [3:0] OP_SC   = 4'd3;
  localparam logic [3:0] OP_SWAP = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_MIN  = 4'd9;
  localparam logic [3:0] OP_MAX  = 4'd10;
  localparam logic [3:0] OP_MINU = 4'd11;
  localparam logic [3:0] OP_MAXU = 4'd12;

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

  state_t                 state_r, state_s;
  logic [3:0]             op_r, op_s;
  logic [XLEN-1:0]        wdata_r, wdata_s;
  logic                   stall_r, stall_s, lock_r, lock_s;
  logic                   rsv_valid_r, rsv_valid_s;
  logic [XLEN-1:RSV_GRAN] rsv_adr_r, rsv_adr_s;
  logic                   aligned_s, rsv_hit_s, lt_s, ltu_s;
  logic [XLEN-1:0]        raw_s, old_s, opb_s, old_u_s, opb_u_s, new_s;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    logic signed [31:0] w;
    w = $signed(v[31:0]);
    return XLEN'(w);
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
    return XLEN'(v[31:0]);
  endfunction

  assign idle_s      = (state_r == IDLE);
  assign rsv_hit_s   = rsv_valid_r & (rsv_adr_r == adr_i[XLEN-1:RSV_GRAN]);
  assign lsu_stall_o = stall_r;
  assign dmem_lock_o = lock_r;

  // Atomics are word or doubleword only and must be naturally aligned
  always_comb begin
    aligned_s = 1'b0;
    case (size_i)
      WORD:    aligned_s = (adr_i[1:0] == 2'b00);
      DWORD:   aligned_s = (XLEN == 64) && (adr_i[2:0] == 3'b000);
      default: aligned_s = 1'b0;
    endcase
  end

  // Old memory value extraction and read-modify-write result; compare width follows size
  always_comb begin
    raw_s = dmem_q_i >> {adr_r[LB-1:0], 3'b000};
    if (size_r == WORD) begin
      old_s   = sext32(raw_s);
      opb_s   = sext32(wdata_r);
      old_u_s = zext32(raw_s);
      opb_u_s = zext32(wdata_r);
    end else begin
      old_s   = raw_s;
      opb_s   = wdata_r;
      old_u_s = raw_s;
      opb_u_s = wdata_r;
    end
    lt_s  = $signed(old_s) < $signed(opb_s);
    ltu_s = old_u_s < opb_u_s;
    case (op_r)
      OP_ADD:  new_s = old_s + opb_s;
      OP_AND:  new_s = old_s & opb_s;
      OP_OR:   new_s = old_s | opb_s;
      OP_XOR:  new_s = old_s ^ opb_s;
      OP_MIN:  new_s = lt_s  ? old_s : opb_s;
      OP_MAX:  new_s = lt_s  ? opb_s : old_s;
      OP_MINU: new_s = ltu_s ? old_s : opb_s;
      OP_MAXU: new_s = ltu_s ? opb_s : old_s;
      default: new_s = opb_s;
    endcase
  end

  // Sequencer next-state and next output values
  always_comb begin
    state_s      = state_r;
    op_s         = op_r;
    wdata_s      = wdata_r;
    stall_s      = stall_r;
    lock_s       = lock_r;
    rsv_valid_s  = rsv_valid_r;
    rsv_adr_s    = rsv_adr_r;
    req_s        = 1'b0;
    we_s         = we_r;
    size_s       = size_r;
    adr_s        = adr_r;
    d_s          = d_r;
    r_s          = r_r;
    bubble_s     = 1'b1;
    misaligned_s = dmem_ack_i & dmem_misaligned_i;
    page_fault_s = dmem_ack_i & dmem_page_fault_i;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          case (op_i)
            OP_LOAD, OP_STORE: begin
              req_s    = 1'b1;
              we_s     = (op_i == OP_STORE);
              size_s   = size_i;
              adr_s    = adr_i;
              d_s      = lane_shift(wdata_i, adr_i);
              bubble_s = 1'b0;
              if ((op_i == OP_STORE) && rsv_hit_s) rsv_valid_s = 1'b0;
              else                                 rsv_valid_s = rsv_valid_r;
            end
            OP_LR, OP_SC, OP_SWAP, OP_ADD, OP_AND, OP_OR, OP_XOR,
            OP_MIN, OP_MAX, OP_MINU, OP_MAXU: begin
              op_s    = op_i;
              wdata_s = wdata_i;
              if (!aligned_s) begin
                misaligned_s = 1'b1;
                bubble_s     = 1'b0;
              end else if (op_i == OP_SC) begin
                if (rsv_hit_s) begin
                  req_s   = 1'b1;
                  we_s    = 1'b1;
                  size_s  = size_i;
                  adr_s   = adr_i;
                  d_s     = lane_shift(wdata_i, adr_i);
                  stall_s = 1'b1;
                  lock_s  = 1'b0;
                  state_s = WR;
                end else begin
                  r_s      = {{(XLEN-1){1'b0}}, 1'b1};
                  bubble_s = 1'b0;
                end
              end else begin
                req_s   = 1'b1;
                we_s    = 1'b0;
                size_s  = size_i;
                adr_s   = adr_i;
                stall_s = 1'b1;
                lock_s  = (op_i != OP_LR);
                state_s = RD;
              end
              // SC always consumes the reservation; an AMO write to the granule kills it
              if ((op_i == OP_SC) || ((op_i != OP_LR) && rsv_hit_s)) rsv_valid_s = 1'b0;
              else                                                  rsv_valid_s = rsv_valid_r;
            end
            default: bubble_s = 1'b1;
          endcase
        end else begin
          bubble_s = 1'b1;
        end
      end
      RD: begin
        if (dmem_ack_i) begin
          if (biu_err_s) begin
            lock_s   = 1'b0;
            stall_s  = 1'b0;
            bubble_s = 1'b0;
            state_s  = IDLE;
          end else if (op_r == OP_LR) begin
            r_s         = old_s;
            lock_s      = 1'b0;
            stall_s     = 1'b0;
            bubble_s    = 1'b0;
            rsv_valid_s = 1'b1;
            rsv_adr_s   = adr_r[XLEN-1:RSV_GRAN];
            state_s     = IDLE;
          end else begin
            r_s     = old_s;
            req_s   = 1'b1;
            we_s    = 1'b1;
            d_s     = lane_shift(new_s, adr_r);
            state_s = WR;
          end
        end else begin
          state_s = RD;
        end
      end
      WR: begin
        if (dmem_ack_i) begin
          lock_s   = 1'b0;
          stall_s  = 1'b0;
          bubble_s = 1'b0;
          we_s     = 1'b0;
          state_s  = IDLE;
          if ((op_r == OP_SC) && !biu_err_s) r_s = '0;
          else                               r_s = r_r;
        end else begin
          state_s = WR;
        end
      end
      default: begin
        state_s = IDLE;
        stall_s = 1'b0;
        lock_s  = 1'b0;
      end
    endcase
    rsv_valid_s = rsv_valid_s & ~(misaligned_s | page_fault_s);
  end

  // Sequencer state, captured operand and reservation
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      op_r        <= 4'd0;
      wdata_r     <= '0;
      stall_r     <= 1'b0;
      lock_r      <= 1'b0;
      rsv_valid_r <= 1'b0;
      rsv_adr_r   <= '0;
    end else begin
      state_r     <= state_s;
      op_r        <= op_s;
      wdata_r     <= wdata_s;
      stall_r     <= stall_s;
      lock_r      <= lock_s;
      rsv_valid_r <= rsv_valid_s;
      rsv_adr_r   <= rsv_adr_s;
    end
  end
`else
  logic unused_s;
  localparam int UNUSED_GRAN = RSV_GRAN;

  assign idle_s      = 1'b1;
  assign lsu_stall_o = 1'b0;
  assign dmem_lock_o = 1'b0;
  assign unused_s    = ^dmem_q_i ^ biu_err_s;

  // Plain load/store issue; every other opcode is a no-op
  always_comb begin
    req_s        = 1'b0;
    we_s         = we_r;
    size_s       = size_r;
    adr_s        = adr_r;
    d_s          = d_r;
    r_s          = r_r;
    bubble_s     = 1'b1;
    misaligned_s = dmem_ack_i & dmem_misaligned_i;
    page_fault_s = dmem_ack_i & dmem_page_fault_i;
    if (accept_s && ((op_i == OP_LOAD) || (op_i == OP_STORE))) begin
      req_s    = 1'b1;
      we_s     = (op_i == OP_STORE);
      size_s   = size_i;
      adr_s    = adr_i;
      d_s      = lane_shift(wdata_i, adr_i);
      bubble_s = 1'b0;
    end else begin
      bubble_s = 1'b1;
    end
  end
`endif

  // Registered BIU request and result outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_r        <= 1'b0;
      we_r         <= 1'b0;
      bubble_r     <= 1'b1;
      misaligned_r <= 1'b0;
      page_fault_r <= 1'b0;
      size_r       <= UNDEF_SIZE;
      adr_r        <= '0;
      d_r          <= '0;
      r_r          <= '0;
    end else begin
      req_r        <= req_s;
      we_r         <= we_s;
      bubble_r     <= bubble_s;
      misaligned_r <= misaligned_s;
      page_fault_r <= page_fault_s;
      size_r       <= size_s;
      adr_r        <= adr_s;
      d_r          <= d_s;
      r_r          <= r_s;
    end
  end

  assign dmem_req_o       = req_r;
  assign dmem_we_o        = we_r;
  assign dmem_size_o      = size_r;
  assign dmem_adr_o       = adr_r;
  assign dmem_d_o         = d_r;
  assign lsu_bubble_o     = bubble_r;
  assign lsu_r_o          = r_r;
  assign lsu_misaligned_o = misaligned_r;
  assign lsu_page_fault_o = page_fault_r;

endmodule

// File: tb/tb_riscv_lsu_amo.sv
// Scoreboard bench for riscv_lsu_amo (XLEN=32): stimulus pushes expected BIU requests and
// results, a negedge monitor pops and compares them, a small BIU model acks every request.
`timescale 1ns/1ps
module tb_riscv_lsu_amo;
  import riscv_lsu_amo_pkg::*;

  localparam logic [3:0] OP_LOAD = 4'd0, OP_STORE = 4'd1, OP_LR = 4'd2, OP_SC = 4'd3,
                         OP_SWAP = 4'd4, OP_ADD = 4'd5, OP_MAX = 4'd10, OP_MAXU = 4'd12;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ex_stall = 1'b0, op_valid = 1'b0;
  logic [3:0]  op = 4'd15;
  biu_size_t   size = WORD;
  logic [31:0] adr = 32'h0, wdata = 32'h0;
  logic        lsu_stall, lsu_bubble, lsu_mis, lsu_pf;
  logic [31:0] lsu_r;
  logic        dmem_req, dmem_lock, dmem_we;
  biu_size_t   dmem_size;
  logic [31:0] dmem_adr, dmem_d;
  logic        dmem_ack = 1'b0, dmem_mis = 1'b0, dmem_pf = 1'b0;
  logic [31:0] dmem_q = 32'h0;

  riscv_lsu_amo #(.XLEN(32), .RSV_GRAN(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ex_stall_i(ex_stall), .op_valid_i(op_valid), .op_i(op),
    .size_i(size), .adr_i(adr), .wdata_i(wdata), .lsu_stall_o(lsu_stall),
    .lsu_bubble_o(lsu_bubble), .lsu_r_o(lsu_r), .lsu_misaligned_o(lsu_mis),
    .lsu_page_fault_o(lsu_pf), .dmem_req_o(dmem_req), .dmem_lock_o(dmem_lock),
    .dmem_we_o(dmem_we), .dmem_size_o(dmem_size), .dmem_adr_o(dmem_adr), .dmem_d_o(dmem_d),
    .dmem_ack_i(dmem_ack), .dmem_q_i(dmem_q), .dmem_misaligned_i(dmem_mis),
    .dmem_page_fault_i(dmem_pf)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic lock; logic stall; logic [31:0] adr;
                   logic chk_d; logic [31:0] d; biu_size_t size; } req_exp_t;
  typedef struct { logic chk_r; logic [31:0] r; logic mis; logic pf; } res_exp_t;

  req_exp_t    req_q[$];
  res_exp_t    res_q[$];
  req_exp_t    mon_req;
  res_exp_t    mon_res;
  logic [31:0] mem [logic [31:0]];
  logic        inj_pf = 1'b0;
  int          checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void exp_req(input logic we, input logic lock, input logic stall,
                                  input logic [31:0] a, input logic chk_d, input logic [31:0] d,
                                  input biu_size_t sz);
    req_q.push_back('{we, lock, stall, a, chk_d, d, sz});
  endfunction

  function automatic void exp_res(input logic chk_r, input logic [31:0] r, input logic mis,
                                  input logic pf);
    res_q.push_back('{chk_r, r, mis, pf});
  endfunction

  // BIU model: acknowledge each request on the following clock edge
  always @(negedge clk) begin
    dmem_ack = dmem_req;
    dmem_pf  = dmem_req & inj_pf;
    if (dmem_req) begin
      if (dmem_we && !inj_pf) mem[{dmem_adr[31:2], 2'b00}] = dmem_d;
      dmem_q = mem.exists({dmem_adr[31:2], 2'b00}) ? mem[{dmem_adr[31:2], 2'b00}] : 32'h0;
    end
  end

  // Monitor: compare every presented request and result against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (dmem_req) begin
        if (req_q.size() == 0) chk("unexpected_req", {32'h0, dmem_adr}, 64'hFFFF_FFFF);
        else begin
          mon_req = req_q.pop_front();
          chk("req_we", dmem_we, mon_req.we);
          chk("req_lock", dmem_lock, mon_req.lock);
          chk("req_stall", lsu_stall, mon_req.stall);
          chk("req_adr", dmem_adr, mon_req.adr);
          chk("req_size", 64'(dmem_size), 64'(mon_req.size));
          if (mon_req.chk_d) chk("req_d", dmem_d, mon_req.d);
        end
      end
      if (!lsu_bubble || lsu_mis || lsu_pf) begin
        if (res_q.size() == 0) chk("unexpected_result", {lsu_bubble, lsu_mis, lsu_pf}, 64'h4);
        else begin
          mon_res = res_q.pop_front();
          chk("res_bubble", lsu_bubble, 1'b0);
          chk("res_mis", lsu_mis, mon_res.mis);
          chk("res_pf", lsu_pf, mon_res.pf);
          chk("res_stall", lsu_stall, 1'b0);
          chk("res_lock", dmem_lock, 1'b0);
          if (mon_res.chk_r) chk("res_r", lsu_r, mon_res.r);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (lsu_stall && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("stall_timeout", lsu_stall, 1'b0);
  endtask

  task automatic issue(input logic [3:0] o, input biu_size_t sz, input logic [31:0] a,
                       input logic [31:0] wd);
    wait_idle();
    op = o; size = sz; adr = a; wdata = wd; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 4'd15;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", lsu_stall, 1'b0);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_lock", dmem_lock, 1'b0);
    chk("rst_we", dmem_we, 1'b0);
    chk("rst_mis", lsu_mis, 1'b0);
    chk("rst_pf", lsu_pf, 1'b0);
    chk("rst_bubble", lsu_bubble, 1'b1);
    chk("rst_r", lsu_r, 32'h0);
    chk("rst_size", 64'(dmem_size), 64'(UNDEF_SIZE));
    chk("rst_adr", dmem_adr, 32'h0);
    chk("rst_d", dmem_d, 32'h0);
    rst_n = 1'b1;

    exp_req(1'b0, 1'b0, 1'b0, 32'h104, 1'b0, 32'h0, WORD);
    exp_res(1'b0, 32'h0, 1'b0, 1'b0);
    issue(OP_LOAD, WORD, 32'h104, 32'h0);
    exp_req(1'b1, 1'b0, 1'b0, 32'h103, 1'b1, 32'hA500_0000, BYTE);
    exp_res(1'b0, 32'h0, 1'b0, 1'b0);
    issue(OP_STORE, BYTE, 32'h103, 32'hA5);
    exp_req(1'b1, 1'b0, 1'b0, 32'h102, 1'b1, 32'h1234_0000, HWORD);
    exp_res(1'b0, 32'h0, 1'b0, 1'b0);
    issue(OP_STORE, HWORD, 32'h102, 32'h1234);

    // held op under ex_stall must not be accepted until the stall drops
    op = OP_LOAD; size = WORD; adr = 32'h800; op_valid = 1'b1; ex_stall = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_req(1'b0, 1'b0, 1'b0, 32'h800, 1'b0, 32'h0, WORD);
    exp_res(1'b0, 32'h0, 1'b0, 1'b0);
    ex_stall = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 4'd15;

`ifdef RV12_LSU_AMO_EN
    mem[32'h200] = 32'h10;
    exp_req(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, WORD);
    exp_req(1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h15, WORD);
    exp_res(1'b1, 32'h10, 1'b0, 1'b0);
    issue(OP_ADD, WORD, 32'h200, 32'h5);

    mem[32'h300] = 32'hCAFE_0001;
    exp_req(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, WORD);
    exp_res(1'b1, 32'hCAFE_0001, 1'b0, 1'b0);
    issue(OP_LR, WORD, 32'h300, 32'h0);
    exp_req(1'b1, 1'b0, 1'b1, 32'h304, 1'b1, 32'h77, WORD);
    exp_res(1'b1, 32'h0, 1'b0, 1'b0);
    issue(OP_SC, WORD, 32'h304, 32'h77);
    exp_res(1'b1, 32'h1, 1'b0, 1'b0);
    issue(OP_SC, WORD, 32'h304, 32'h78);

    mem[32'h400] = 32'hFFFF_FFFF;
    exp_req(1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0, WORD);
    exp_req(1'b1, 1'b1, 1'b1, 32'h400, 1'b1, 32'h1, WORD);
    exp_res(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    issue(OP_MAX, WORD, 32'h400, 32'h1);
    wait_idle();
    mem[32'h400] = 32'hFFFF_FFFF;
    exp_req(1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0, WORD);
    exp_req(1'b1, 1'b1, 1'b1, 32'h400, 1'b1, 32'hFFFF_FFFF, WORD);
    exp_res(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    issue(OP_MAXU, WORD, 32'h400, 32'h1);

    exp_res(1'b0, 32'h0, 1'b1, 1'b0);
    issue(OP_SWAP, WORD, 32'h202, 32'h9);
    exp_res(1'b0, 32'h0, 1'b1, 1'b0);
    issue(OP_SWAP, HWORD, 32'h210, 32'h9);

    inj_pf = 1'b1;
    exp_req(1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0, WORD);
    exp_res(1'b0, 32'h0, 1'b0, 1'b1);
    issue(OP_SWAP, WORD, 32'h500, 32'h9);
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    inj_pf = 1'b0;

    // a plain store into the reserved granule kills the reservation
    exp_req(1'b0, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0, WORD);
    exp_res(1'b1, 32'h0, 1'b0, 1'b0);
    issue(OP_LR, WORD, 32'h600, 32'h0);
    exp_req(1'b1, 1'b0, 1'b0, 32'h604, 1'b1, 32'h1, WORD);
    exp_res(1'b0, 32'h0, 1'b0, 1'b0);
    issue(OP_STORE, WORD, 32'h604, 32'h1);
    exp_res(1'b1, 32'h1, 1'b0, 1'b0);
    issue(OP_SC, WORD, 32'h600, 32'h2);

    exp_req(1'b0, 1'b1, 1'b1, 32'h700, 1'b0, 32'h0, WORD);
    issue(OP_ADD, WORD, 32'h700, 32'h1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_lock", dmem_lock, 1'b0);
    chk("arst_stall", lsu_stall, 1'b0);
    chk("arst_req", dmem_req, 1'b0);
    chk("arst_bubble", lsu_bubble, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
`else
    issue(OP_LR, WORD, 32'h300, 32'h0);
    issue(OP_ADD, WORD, 32'h200, 32'h5);
    repeat (2) @(posedge clk);
    #1;
    chk("noop_stall", lsu_stall, 1'b0);
    chk("noop_lock", dmem_lock, 1'b0);
    chk("noop_bubble", lsu_bubble, 1'b1);
`endif

    repeat (6) @(posedge clk);
    #1;
    chk("req_q_drained", req_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_lsu_amo.md
Name: riscv_lsu_amo

Overview:
Next-generation load/store unit for the RV12 EX stage, parametrised in XLEN.
- Plain LOAD/STORE: single-cycle, fully pipelined memory request issue.
- A-extension: LR/SC with a reservation register and locked read-modify-write AMOs, driven by a multi-cycle FSM that stalls the pipeline.
- Sits between the ID/EX operand path and the data BIU interface.

Parameters:
XLEN, 32, data/address width (32 or 64).
RSV_GRAN, 3, reservation granule as log2 bytes; address bits [RSV_GRAN-1:0] are ignored in the reservation compare.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  reset; asynchronous, active-low.
ex_stall_i  in  1  pipeline stall; no new op is accepted while high.
op_valid_i  in  1  valid non-bubble op with no upstream exception.
op_i  in  4  0=LOAD 1=STORE 2=LR 3=SC 4=SWAP 5=ADD 6=AND 7=OR 8=XOR 9=MIN 10=MAX 11=MINU 12=MAXU; other codes mean no-op.
size_i  in  biu_size_t  access size (BYTE/HWORD/WORD/DWORD).
adr_i  in  XLEN  effective address.
wdata_i  in  XLEN  store/AMO operand, right-aligned.
lsu_stall_o  out  1  LSU busy.
lsu_bubble_o  out  1  no valid result this cycle.
lsu_r_o  out  XLEN  AMO/LR old value or SC status.
lsu_misaligned_o  out  1  registered exception flag.
lsu_page_fault_o  out  1  registered exception flag.
dmem_req_o, dmem_lock_o, dmem_we_o  out  1 each  BIU request, bus lock, write enable.
dmem_size_o  out  biu_size_t  BIU access size.
dmem_adr_o, dmem_d_o  out  XLEN each  BIU address and write data.
dmem_ack_i  in  1  BIU acknowledge.
dmem_q_i  in  XLEN  BIU read data.
dmem_misaligned_i, dmem_page_fault_i  in  1 each  BIU error indications.

Behaviour:
- Reset values:
  - State IDLE; reservation invalid.
  - stall, req, lock, we, misaligned, page_fault = 0; bubble = 1; lsu_r_o = 0.
  - dmem_size_o = UNDEF_SIZE; dmem_adr_o = 0; dmem_d_o = 0.
- Accept condition: IDLE && op_valid_i && !ex_stall_i.
- dmem_req_o is a one-cycle pulse per memory phase.
- Store data is shifted to byte lane adr[log2(XLEN/8)-1:0].
- LOAD/STORE:
  - Cycle after accept: req=1, lock=0, we=(STORE), bubble=0.
  - FSM stays in IDLE; stall stays 0.
- Alignment check for LR/SC/AMO only, at accept:
  - The address must be aligned to the access size; only WORD/DWORD sizes are legal.
  - On failure: no request is issued; lsu_misaligned_o=1 and bubble=0 for one cycle.
- FSM states: IDLE, RD, WR.
- AMO sequence:
  - Accept → RD: req=1, we=0, lock=1, stall=1.
  - In RD on ack: capture dmem_q_i (sign-extended for WORD when XLEN=64) into lsu_r_o and compute the new value.
  - Next cycle → WR: req=1, we=1, lock=1, d=new value.
  - In WR on ack: lock=0, stall=0, bubble=0 for one cycle, → IDLE.
  - MIN/MAX compare signed; MINU/MAXU compare unsigned; the compare width follows size.
- LR: same as the AMO read phase with lock=0. On ack, set the reservation to adr[XLEN-1:RSV_GRAN] and return to IDLE.
- SC:
  - Reservation valid and address match: issue the write via WR; lsu_r_o=0 on ack.
  - Otherwise: no request; lsu_r_o=1 and bubble=0 the cycle after accept.
  - The reservation is cleared in both cases.
- Reservation is also cleared by:
  - any STORE or AMO write to the same granule;
  - any exception.
- BIU error:
  - dmem_misaligned_i or dmem_page_fault_i together with ack in RD or WR aborts the op.
  - On abort: no further write, lock=0, stall=0, the matching exception flag=1 for one cycle, → IDLE.
- Ops presented while stall=1 are ignored. The pipeline holds the op; it is not queued.
- Asynchronous reset mid-AMO returns all outputs to reset values immediately; lock drops.

Optional Feature:
Macro RV12_LSU_AMO_EN.
- Defined: LR/SC/AMO behave as above.
- Undefined:
  - Only LOAD/STORE are supported; op codes 2-12 are treated as no-op (bubble=1, no request).
  - The FSM and reservation logic are not instantiated; stall and lock are tied to 0.

Test Plan:
1. LOAD WORD at 0x104 → next cycle req=1, we=0, adr=0x104, lock=0, stall=0.
2. STORE BYTE 0xA5 at 0x103 (XLEN=32) → dmem_d_o=0xA5000000, we=1, size=BYTE.
3. AMOADD WORD at 0x200, memory 0x10, wdata 0x5:
   - read is locked; ack returns 0x10; write d=0x15 with lock=1.
   - After write ack: lsu_r_o=0x10, stall deasserts.
4. LR at 0x300 then SC at 0x304 (RSV_GRAN=3) → SC writes, lsu_r_o=0. A second SC → no request, lsu_r_o=1.
5. AMOMAX signed, memory 0xFFFFFFFF, wdata 0x1 → write d=0x1; AMOMAXU on the same values → write d=0xFFFFFFFF.
6. Misaligned and abort cases:
   - AMOSWAP at 0x202 → no request, lsu_misaligned_o=1.
   - Page fault with ack in RD → no write, lsu_page_fault_o=1, lock=0.
